// File: rtl/dlx_debug_ctrl_if.sv
// UART byte-FIFO handshake bundle: the debug controller is the master, the FIFO pair is the slave.
interface dlx_debug_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       wr;

  modport master (input rx_data, rx_empty, tx_full, output rd, tx_data, wr);
  modport slave  (output rx_data, rx_empty, tx_full, input rd, tx_data, wr);
endinterface

// File: rtl/dlx_debug_ctrl.sv
// Host command sequencer for the DLX core: decodes run/step/pause/dump bytes, gates the core
// enable, and streams a snapshot of the debug vector LSB-first into the UART transmit FIFO.
module dlx_debug_ctrl #(
  parameter int unsigned DEBUG_BYTES = 4,
  parameter logic [7:0]  CMD_RUN     = 8'h63,
  parameter logic [7:0]  CMD_STEP    = 8'h73,
  parameter logic [7:0]  CMD_PAUSE   = 8'h70,
  parameter logic [7:0]  CMD_DUMP    = 8'h72
) (
  input  logic                     clock,
  input  logic                     reset,
  dlx_debug_ctrl_if.master         uart,
  input  logic [DEBUG_BYTES*8-1:0] debug_signal,
  input  logic                     halt,
  output logic                     enable,
  output logic                     busy
);

  localparam int unsigned      IDX_W    = (DEBUG_BYTES > 1) ? $clog2(DEBUG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEBUG_BYTES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] STEP   = 3'd3;
  localparam logic [2:0] SNAP   = 3'd4;
  localparam logic [2:0] SEND   = 3'd5;

  logic [2:0]               state;
  logic [2:0]               state_next;
  logic [7:0]               cmd;
  logic [DEBUG_BYTES*8-1:0] snapshot;
  logic [IDX_W-1:0]         idx;
  logic                     pop;
  logic                     push;

  // In RUN, halt has priority over a queued pause byte; any other queued byte is left untouched.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!uart.rx_empty) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        case (cmd)
          CMD_RUN:  state_next = halt ? SNAP : RUN;
          CMD_STEP: state_next = halt ? SNAP : STEP;
          CMD_DUMP: state_next = SNAP;
          default:  state_next = IDLE;
        endcase
      end
      RUN: begin
        if (halt) begin
          state_next = SNAP;
        end else if (!uart.rx_empty && (uart.rx_data == CMD_PAUSE)) begin
          pop        = 1'b1;
          state_next = SNAP;
        end
      end
      STEP: state_next = SNAP;
      SNAP: state_next = SEND;
      SEND: begin
        if (!uart.tx_full) begin
          push = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot is frozen at SNAP so the frame in flight never sees later core activity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cmd      <= 8'h00;
      snapshot <= '0;
      idx      <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && pop) begin
        cmd <= uart.rx_data;
      end
      if (state == SNAP) begin
        snapshot <= debug_signal;
        idx      <= '0;
      end else if (push) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign uart.rd      = pop && reset;
  assign uart.wr      = push;
  assign uart.tx_data = snapshot[{idx, 3'b000} +: 8];
  assign enable       = (state == RUN) || (state == STEP);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dlx_debug_ctrl.sv
// Directed bench for dlx_debug_ctrl: a FIFO model plus an expected-frame scoreboard checked
// every cycle, with literal checks on latency, counts and specific frame bytes.
module tb_dlx_debug_ctrl;
  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB*8-1:0] debug_signal;
  logic          halt;
  logic          enable;
  logic          busy;

  dlx_debug_ctrl_if uart();

  dlx_debug_ctrl #(.DEBUG_BYTES(NB)) dut (
    .clock(clock),
    .reset(reset),
    .uart(uart),
    .debug_signal(debug_signal),
    .halt(halt),
    .enable(enable),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_count, wr_count, en_count;
  int rd_last, en_first, en_last, wr_first;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sent[$];
  logic       pop_pending = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_tx = 8'h00;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic flag_error(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0h, required no event", name, act);
  endtask

  // Scoreboard: every push must carry the next expected frame byte; stalls must hold the bus.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      check_output("reset_enable", enable, 0);
      check_output("reset_wr", uart.wr, 0);
      check_output("reset_rd", uart.rd, 0);
      check_output("reset_busy", busy, 0);
      prev_stall = 1'b0;
    end else begin
      if (uart.rd) begin
        rd_count++;
        rd_last = cyc;
        if (rx_q.size() == 0) flag_error("rd_on_empty", uart.rd);
        else pop_pending = 1'b1;
      end
      if (enable) begin
        en_count++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
        check_output("enable_implies_busy", busy, 1);
      end
      if (uart.wr) begin
        wr_count++;
        if (wr_first < 0) wr_first = cyc;
        sent.push_back(uart.tx_data);
        if (exp_q.size() == 0) flag_error("unexpected_wr", uart.tx_data);
        else check_output("tx_byte", uart.tx_data, exp_q.pop_front());
      end
      if (uart.tx_full) begin
        check_output("wr_while_full", uart.wr, 0);
        if (prev_stall && busy) check_output("tx_hold", uart.tx_data, prev_tx);
      end
      prev_stall = uart.tx_full && busy;
      prev_tx    = uart.tx_data;
    end
  end

  // Receive FIFO model: the pop lands after the edge that consumed the head byte.
  always @(posedge clock) begin
    if (pop_pending && reset) void'(rx_q.pop_front());
    pop_pending = 1'b0;
    uart.rx_empty <= (rx_q.size() == 0);
    uart.rx_data  <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] b);
    rx_q.push_back(b);
    uart.rx_empty = 1'b0;
    uart.rx_data  = rx_q[0];
  endtask

  task automatic expect_frame(input logic [NB*8-1:0] v);
    for (int i = 0; i < NB; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic clear_counts();
    rd_count = 0; wr_count = 0; en_count = 0;
    rd_last = -1; en_first = -1; en_last = -1; wr_first = -1;
    sent.delete();
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (!(busy == 1'b0 && rx_q.size() == 0) && k < budget);
    if (k >= budget) flag_error({name, "_timeout"}, k);
  endtask

  task automatic wait_wr(input string name, input int n, input int budget);
    int k = 0;
    while (wr_count < n && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) flag_error({name, "_timeout"}, wr_count);
  endtask

  task automatic apply_stimulus();
    int k;
    // Reset state and idle quiescence
    reset = 1'b0; halt = 1'b0; debug_signal = '0;
    uart.rx_empty = 1'b1; uart.rx_data = 8'h00; uart.tx_full = 1'b0;
    #2;
    check_output("rst_tx_data", uart.tx_data, 8'h00);
    check_output("rst_enable", enable, 0);
    step(2);
    reset = 1'b1;
    clear_counts();
    step(20);
    check_output("idle_rd_count", rd_count, 0);
    check_output("idle_en_count", en_count, 0);
    check_output("idle_wr_count", wr_count, 0);
    check_output("idle_busy", busy, 0);

    // Single step
    clear_counts();
    debug_signal = 32'hA1B2C3D4;
    expect_frame(debug_signal);
    push_cmd(8'h73);
    wait_quiet("step", 100);
    check_output("step_rd_count", rd_count, 1);
    check_output("step_en_count", en_count, 1);
    check_output("step_en_latency", en_first - rd_last, 2);
    check_output("step_wr_latency", wr_first - rd_last, 4);
    check_output("step_wr_count", wr_count, 4);
    check_output("step_byte0", sent[0], 8'hD4);
    check_output("step_byte3", sent[3], 8'hA1);

    // Run until halt; snapshot isolation while the frame is in flight
    clear_counts();
    debug_signal = 32'h12345678;
    expect_frame(debug_signal);
    push_cmd(8'h63);
    k = 0;
    while (en_count < 50 && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) flag_error("run_en_timeout", en_count);
    halt = 1'b1;
    step(2);
    debug_signal = 32'hDEADBEEF;
    wait_quiet("run_halt", 100);
    halt = 1'b0;
    check_output("halt_en_count", en_count, 51);
    check_output("halt_rd_count", rd_count, 1);
    check_output("halt_wr_count", wr_count, 4);
    check_output("halt_byte0", sent[0], 8'h78);

    // Run then pause
    clear_counts();
    debug_signal = 32'h0BADF00D;
    expect_frame(debug_signal);
    push_cmd(8'h63);
    step(30);
    push_cmd(8'h70);
    wait_quiet("pause", 100);
    check_output("pause_rd_count", rd_count, 2);
    check_output("pause_en_stop", en_last, rd_last);
    check_output("pause_wr_count", wr_count, 4);

    // Run with a non-pause byte queued: no pop, core keeps running until halt
    clear_counts();
    debug_signal = 32'h55AA33CC;
    push_cmd(8'h63);
    step(10);
    push_cmd(8'h78);
    step(20);
    check_output("other_rd_count", rd_count, 1);
    check_output("other_enable", enable, 1);
    check_output("other_queued", rx_q.size(), 1);
    expect_frame(debug_signal);
    halt = 1'b1;
    wait_quiet("other_halt", 100);
    halt = 1'b0;
    check_output("other_rd_after", rd_count, 2);
    check_output("other_wr_count", wr_count, 4);

    // Dump with back-pressure after two bytes
    clear_counts();
    debug_signal = 32'hCAFEF00D;
    expect_frame(debug_signal);
    push_cmd(8'h72);
    wait_wr("dump", 2, 50);
    uart.tx_full = 1'b1;
    #1;
    check_output("stall_byte", uart.tx_data, 8'hFE);
    check_output("stall_wr", uart.wr, 0);
    step(10);
    uart.tx_full = 1'b0;
    wait_quiet("dump", 100);
    check_output("dump_wr_count", wr_count, 4);
    check_output("dump_byte2", sent[2], 8'hFE);
    check_output("dump_en_count", en_count, 0);

    // Reset during RUN
    clear_counts();
    push_cmd(8'h63);
    step(10);
    #3 reset = 1'b0;
    #1;
    check_output("abort_run_enable", enable, 0);
    check_output("abort_run_busy", busy, 0);
    step(2);
    reset = 1'b1;

    // Reset during SEND byte 2
    clear_counts();
    debug_signal = 32'h89ABCDEF;
    expect_frame(debug_signal);
    push_cmd(8'h72);
    wait_wr("abort_send", 2, 50);
    #2 reset = 1'b0;
    #1;
    check_output("abort_send_wr", uart.wr, 0);
    check_output("abort_send_busy", busy, 0);
    exp_q.delete();
    step(2);
    reset = 1'b1;

    // Recovery step produces a complete frame
    clear_counts();
    debug_signal = 32'h01020304;
    expect_frame(debug_signal);
    push_cmd(8'h73);
    wait_quiet("recover", 100);
    check_output("recover_wr_count", wr_count, 4);
    check_output("recover_byte0", sent[0], 8'h04);
    check_output("recover_pending", exp_q.size(), 0);
  endtask

  initial begin
    apply_stimulus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
